// File: rtl/johnson_counter_scheduler_if.sv
// Requester-side bus of the Johnson counter scheduler.
//   Req_In     : level request per requester, held until its Done_Out pulse
//   Steps_In   : per-requester shift count, requester i at [i*STEP_W +: STEP_W]
//   Grant_Out  : one-hot owner of the counter, zero when idle
//   Done_Out   : one-cycle completion pulse to the owner
//   Err_Out    : one-cycle pulse with Done_Out when the run timed out
//   Result_Out : counter value captured at end of run
//   Busy_Out   : scheduler not idle
// master = requester side, slave = scheduler side.
interface johnson_counter_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int STEP_W  = 8
);
    logic [NUM_REQ-1:0]        Req_In;
    logic [NUM_REQ*STEP_W-1:0] Steps_In;
    logic [NUM_REQ-1:0]        Grant_Out;
    logic [NUM_REQ-1:0]        Done_Out;
    logic                      Err_Out;
    logic [31:0]               Result_Out;
    logic                      Busy_Out;

    modport master (
        output Req_In, Steps_In,
        input  Grant_Out, Done_Out, Err_Out, Result_Out, Busy_Out
    );

    modport slave (
        input  Req_In, Steps_In,
        output Grant_Out, Done_Out, Err_Out, Result_Out, Busy_Out
    );
endinterface

// File: rtl/johnson_counter_scheduler.sv
// Round-robin scheduler that lends one external 32-bit Johnson counter to
// NUM_REQ requesters. Each granted requester gets the counter cleared,
// started, shifted exactly Steps times, stopped, and the final value
// returned in Result_Out.
// Ports:
//   Clk_In         : rising-edge clock
//   tb_Reset_In    : asynchronous active-high reset
//   bus            : requester bus (slave modport)
//   Ctr_Reset_Out  : counter reset (high during and one edge after reset)
//   Ctr_Enable_Out : counter enable, follows Busy_Out
//   Ctr_Start_Out  : counter start pulse
//   Ctr_Stop_Out   : counter stop pulse
//   Ctr_Running_In : counter running flag
//   Ctr_Count_In   : counter value
module johnson_counter_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int STEP_W  = 8,
    parameter int TIMEOUT = 8
) (
    input  logic        Clk_In,
    input  logic        tb_Reset_In,
    johnson_counter_scheduler_if.slave bus,
    output logic        Ctr_Reset_Out,
    output logic        Ctr_Enable_Out,
    output logic        Ctr_Start_Out,
    output logic        Ctr_Stop_Out,
    input  logic        Ctr_Running_In,
    input  logic [31:0] Ctr_Count_In
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ARB, CLEAR, START, WAIT_RUN, RUN, WAIT_STOP, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, owner_q, arb_idx;
    logic               arb_found;
    logic [NUM_REQ-1:0] arb_gnt, owner_gnt;
    logic [STEP_W-1:0]  steps_q, shift_cnt_q, completed;
    logic [TMR_W-1:0]   tmr_q;
    logic               tmr_expired, stop_hit;
    logic               err_q, ctr_rst_q;
    logic [31:0]        result_q;
    int unsigned        cand;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!arb_found && bus.Req_In[IDX_W'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        arb_gnt   = arb_found ? (NUM_REQ'(1) << arb_idx) : '0;
        owner_gnt = NUM_REQ'(1) << owner_q;
    end

    // The edge that ends the WAIT_RUN cycle already performs the first
    // shift, so the completed count is 0 there and the Stop decision for
    // a single-step run is taken in WAIT_RUN itself.
    always_comb begin
        completed   = (state_q == RUN) ? shift_cnt_q : '0;
        stop_hit    = Ctr_Running_In
                      && ((state_q == RUN) || (state_q == WAIT_RUN))
                      && (completed == steps_q - STEP_W'(1));
        tmr_expired = (tmr_q == TMR_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (|bus.Req_In) state_d = ARB;
            ARB:       state_d = arb_found ? CLEAR : IDLE;
            CLEAR:     state_d = (steps_q == '0) ? DONE : START;
            START:     state_d = WAIT_RUN;
            WAIT_RUN: begin
                if (Ctr_Running_In)   state_d = stop_hit ? WAIT_STOP : RUN;
                else if (tmr_expired) state_d = DONE;
            end
            RUN:       if (stop_hit) state_d = WAIT_STOP;
            WAIT_STOP: if (!Ctr_Running_In || tmr_expired) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.Grant_Out  = '0;
        bus.Done_Out   = '0;
        bus.Err_Out    = 1'b0;
        bus.Busy_Out   = (state_q != IDLE);
        bus.Result_Out = result_q;
        if (state_q == ARB)
            bus.Grant_Out = arb_gnt;
        else if (state_q != IDLE)
            bus.Grant_Out = owner_gnt;
        if (state_q == DONE) begin
            bus.Done_Out = owner_gnt;
            bus.Err_Out  = err_q;
        end
        Ctr_Enable_Out = (state_q != IDLE);
        Ctr_Start_Out  = (state_q == START);
        Ctr_Stop_Out   = stop_hit;
        Ctr_Reset_Out  = ctr_rst_q || (state_q == CLEAR);
    end

    always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
        if (tb_Reset_In) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            steps_q     <= '0;
            shift_cnt_q <= '0;
            tmr_q       <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
            ctr_rst_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            ctr_rst_q <= 1'b0;
            tmr_q     <= (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);

            if (state_q == ARB && arb_found) begin
                owner_q <= arb_idx;
                steps_q <= bus.Steps_In[int'(arb_idx)*STEP_W +: STEP_W];
                err_q   <= 1'b0;
            end

            if (state_q == CLEAR && steps_q == '0)
                result_q <= 32'h0000_0001;

            if (state_q == WAIT_RUN) begin
                if (Ctr_Running_In)   shift_cnt_q <= STEP_W'(1);
                else if (tmr_expired) err_q <= 1'b1;
            end

            if (state_q == RUN && Ctr_Running_In)
                shift_cnt_q <= shift_cnt_q + STEP_W'(1);

            if (state_q == WAIT_STOP && (!Ctr_Running_In || tmr_expired)) begin
                result_q <= Ctr_Count_In;
                if (Ctr_Running_In) err_q <= 1'b1;
            end

            if (state_q == DONE)
                rr_ptr_q <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_johnson_counter_scheduler.sv
// Scoreboard bench for johnson_counter_scheduler: a behavioural counter
// stub drives the counter inputs, the driver predicts each batch's service
// order and results, and the monitor checks every Done_Out pulse.
module tb_johnson_counter_scheduler;

    localparam int NUM_REQ = 4;
    localparam int STEP_W  = 8;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    johnson_counter_scheduler_if #(.NUM_REQ(NUM_REQ), .STEP_W(STEP_W)) bus ();

    logic        ctr_reset, ctr_enable, ctr_start, ctr_stop;
    logic        ctr_running;
    logic [31:0] ctr_count;
    bit          stuck_run   = 1'b0;
    bit          ignore_stop = 1'b0;

    johnson_counter_scheduler #(
        .NUM_REQ(NUM_REQ), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk_In         (clk),
        .tb_Reset_In    (rst),
        .bus            (bus),
        .Ctr_Reset_Out  (ctr_reset),
        .Ctr_Enable_Out (ctr_enable),
        .Ctr_Start_Out  (ctr_start),
        .Ctr_Stop_Out   (ctr_stop),
        .Ctr_Running_In (ctr_running),
        .Ctr_Count_In   (ctr_count)
    );

    // Counter stub; stuck_run / ignore_stop inject the two timeout faults.
    always @(posedge clk) begin
        if (ctr_reset) begin
            ctr_count   <= 32'h1;
            ctr_running <= 1'b0;
        end else begin
            if (ctr_running) ctr_count <= {ctr_count[30:0], ~ctr_count[31]};
            if (ctr_start && !stuck_run)      ctr_running <= 1'b1;
            else if (ctr_stop && !ignore_stop) ctr_running <= 1'b0;
        end
    end

    typedef struct {
        int unsigned idx;
        logic [31:0] result;
        logic        err;
        int unsigned starts;
        int unsigned stops;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned model_ptr  = 0;
    logic [31:0] model_result = 32'h0;

    // Johnson pattern after n shifts from 1: k+1 low ones for k<32,
    // then zeros fill in from the bottom; period 64.
    function automatic logic [31:0] jc(input int unsigned n);
        int unsigned k;
        k = n % 64;
        if (k <= 31) return 32'((33'd1 << (k + 1)) - 33'd1);
        else         return ~32'((33'd1 << (k - 31)) - 33'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},  32'(bus.Grant_Out),  32'h0);
        check({tag, "_done"},   32'(bus.Done_Out),   32'h0);
        check({tag, "_err"},    32'(bus.Err_Out),    32'h0);
        check({tag, "_busy"},   32'(bus.Busy_Out),   32'h0);
        check({tag, "_result"}, bus.Result_Out,      32'h0);
        check({tag, "_start"},  32'(ctr_start),      32'h0);
        check({tag, "_stop"},   32'(ctr_stop),       32'h0);
        check({tag, "_enable"}, 32'(ctr_enable),     32'h0);
        check({tag, "_ctrrst"}, 32'(ctr_reset),      32'h1);
    endtask

    task automatic predict(input logic [3:0] reqs, input logic [31:0] steps,
                           input bit stuck, input bit ign);
        exp_t        e;
        int unsigned i, st, last;
        bit          any;
        any  = 1'b0;
        last = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            i = (model_ptr + k) % NUM_REQ;
            if (reqs[i[1:0]]) begin
                st    = 32'(steps[i*STEP_W +: STEP_W]);
                e.idx = i;
                if (st == 0) begin
                    e.result = 32'h1; e.err = 1'b0; e.starts = 0; e.stops = 0;
                end else if (stuck) begin
                    e.result = model_result; e.err = 1'b1; e.starts = 1; e.stops = 0;
                end else if (ign) begin
                    e.result = jc(st + 7); e.err = 1'b1; e.starts = 1; e.stops = 1;
                end else begin
                    e.result = jc(st); e.err = 1'b0; e.starts = 1; e.stops = 1;
                end
                model_result = e.result;
                sb_q.push_back(e);
                last = i;
                any  = 1'b1;
            end
        end
        if (any) model_ptr = (last + 1) % NUM_REQ;
    endtask

    task automatic run_batch(input logic [3:0] reqs, input logic [31:0] steps,
                             input bit stuck, input bit ign, input bit drop_mid);
        bit ok;
        ok = 1'b0;
        predict(reqs, steps, stuck, ign);
        stuck_run    = stuck;
        ignore_stop  = ign;
        bus.Steps_In = steps;
        bus.Req_In   = reqs;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.Req_In = bus.Req_In & ~bus.Done_Out;
            if (drop_mid && ctr_running && bus.Grant_Out != '0 && $urandom_range(0, 3) == 0)
                bus.Req_In = bus.Req_In & ~bus.Grant_Out;
            if (sb_q.size() == 0 && !bus.Busy_Out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("batch_timeout");
        bus.Req_In  = '0;
        stuck_run   = 1'b0;
        ignore_stop = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: per-cycle invariants and scoreboard pops on Done_Out.
    initial begin
        int unsigned        n_start, n_stop;
        logic [NUM_REQ-1:0] prev_gnt, exp_oh;
        int                 pulses;
        exp_t               e;
        n_start  = 0;
        n_stop   = 0;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_start  = 0;
                n_stop   = 0;
                prev_gnt = '0;
            end else begin
                pulses = int'(ctr_start) + int'(ctr_stop) + int'(ctr_reset);
                check("ctl_exclusive", (pulses <= 1) ? 32'h1 : 32'h0, 32'h1);
                check("enable_busy", 32'(ctr_enable), 32'(bus.Busy_Out));
                check("grant_onehot", ($countones(bus.Grant_Out) <= 1) ? 32'h1 : 32'h0, 32'h1);
                if (prev_gnt != '0 && bus.Grant_Out != '0)
                    check("grant_hold", 32'(bus.Grant_Out), 32'(prev_gnt));
                prev_gnt = bus.Grant_Out;
                n_start += int'(ctr_start);
                n_stop  += int'(ctr_stop);
                if (bus.Done_Out == '0) begin
                    check("err_without_done", 32'(bus.Err_Out), 32'h0);
                end else if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got Done_Out=%b expected no pulse", bus.Done_Out);
                end else begin
                    e      = sb_q.pop_front();
                    exp_oh = NUM_REQ'(1) << e.idx;
                    check("done_owner",   32'(bus.Done_Out),  32'(exp_oh));
                    check("done_grant",   32'(bus.Grant_Out), 32'(exp_oh));
                    check("done_err",     32'(bus.Err_Out),   32'(e.err));
                    check("done_result",  bus.Result_Out,     e.result);
                    check("start_pulses", n_start,            e.starts);
                    check("stop_pulses",  n_stop,             e.stops);
                    n_start = 0;
                    n_stop  = 0;
                end
            end
        end
    end

    // Driver
    initial begin
        logic [31:0] s;
        logic [3:0]  r;
        bit          seen;

        rst          = 1'b1;
        bus.Req_In   = '0;
        bus.Steps_In = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        #1 check("ctr_reset_held", 32'(ctr_reset), 32'h1);
        @(posedge clk);
        #1 check("ctr_reset_drop", 32'(ctr_reset), 32'h0);
        @(negedge clk);

        run_batch(4'b0001, 32'd4,               1'b0, 1'b0, 1'b0);
        run_batch(4'b0010, 32'd0,               1'b0, 1'b0, 1'b0);
        run_batch(4'b0100, 32'd40 << 16,        1'b0, 1'b0, 1'b0);
        run_batch(4'b1000, 32'd255 << 24,       1'b0, 1'b0, 1'b0);
        run_batch(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0, 1'b0);
        run_batch(4'b0100, 32'd3 << 16,         1'b0, 1'b1, 1'b0);
        run_batch(4'b0001, 32'd5,               1'b1, 1'b0, 1'b0);
        run_batch(4'b0010, 32'd6 << 8,          1'b0, 1'b0, 1'b0);

        for (int b = 0; b < 20; b++) begin
            r = 4'($urandom_range(1, 15));
            for (int k = 0; k < NUM_REQ; k++)
                s[k*STEP_W +: STEP_W] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                                     : 8'($urandom_range(0, 12));
            run_batch(r, s, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end

        // Abort a long run on requester 2 with an asynchronous reset.
        bus.Steps_In = 32'd200 << 16;
        bus.Req_In   = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ctr_running) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("midrun_wait_running");
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrun");
        sb_q.delete();
        model_ptr    = 0;
        model_result = 32'h0;
        bus.Req_In   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("midrun_ctr_reset_held", 32'(ctr_reset), 32'h1);
        @(posedge clk);
        #1 check("midrun_ctr_reset_drop", 32'(ctr_reset), 32'h0);
        @(negedge clk);

        for (int k = 0; k < NUM_REQ; k++)
            s[k*STEP_W +: STEP_W] = 8'($urandom_range(1, 20));
        run_batch(4'b1111, s, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/johnson_counter_scheduler.md
JOHNSON_COUNTER_SCHEDULER -- requirements
Module: johnson_counter_scheduler

Interface
REQ-001 Parameters: NUM_REQ, 4, number of requesters; STEP_W, 8, width of per-requester step count; TIMEOUT, 8, handshake timeout in cycles.
REQ-002 Clk_In  input  1  rising-edge clock for all state.
REQ-003 tb_Reset_In  input  1  reset, asynchronous, active-high.
REQ-004 Req_In  input  NUM_REQ  level request per requester; held until the matching Done_Out pulse.
REQ-005 Steps_In  input  NUM_REQ*STEP_W  requested shift count; requester i occupies bits [i*STEP_W +: STEP_W].
REQ-006 Grant_Out  output  NUM_REQ  one-hot owner of the counter; all-zero when idle.
REQ-007 Done_Out  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-008 Err_Out  output  1  one-cycle pulse coincident with Done_Out when the run aborted on timeout.
REQ-009 Result_Out  output  32  counter value captured at end of run; held until the next capture.
REQ-010 Busy_Out  output  1  high in every state except IDLE.
REQ-011 Ctr_Reset_Out, Ctr_Enable_Out, Ctr_Start_Out, Ctr_Stop_Out  output  1 each  drive the 32-bit Johnson counter's reset, enable, start and stop inputs.
REQ-012 Ctr_Running_In  input  1  counter running flag.
REQ-013 Ctr_Count_In  input  32  counter value.

Function
REQ-014 Counter model: reset value 0x00000001; on each rising edge with Ctr_Running_In high, count <= {count[30:0], ~count[31]}; period 64.
REQ-015 The FSM SHALL have states IDLE, ARB, CLEAR, START, WAIT_RUN, RUN, WAIT_STOP, DONE.
REQ-016 IDLE -> ARB when any Req_In bit is high; otherwise stay in IDLE.
REQ-017 ARB: round-robin grant starting at the index one above the last granted index (initially index 0 after reset); latch that requester's Steps_In; assert Grant_Out; go to CLEAR.
REQ-018 Grant_Out SHALL stay constant from ARB through DONE; deassertion of Req_In mid-run SHALL be ignored and the run SHALL complete.
REQ-019 CLEAR: Ctr_Reset_Out high for exactly one cycle; next state START, or DONE with Result_Out = 0x00000001 and no Start pulse if latched steps = 0.
REQ-020 START: Ctr_Start_Out high for exactly one cycle; next state WAIT_RUN.
REQ-021 WAIT_RUN: on Ctr_Running_In high go to RUN; after TIMEOUT cycles without it go to DONE with Err_Out.
REQ-022 RUN: count edges with Ctr_Running_In high; assert Ctr_Stop_Out for one cycle when the completed-shift count equals steps-1, so the counter performs exactly `steps` shifts; then go to WAIT_STOP.
REQ-023 WAIT_STOP: on Ctr_Running_In low, capture Ctr_Count_In into Result_Out and go to DONE; after TIMEOUT cycles, capture anyway and flag Err_Out.
REQ-024 DONE: pulse Done_Out[owner] (and Err_Out if flagged) for one cycle; clear Grant_Out; update the round-robin pointer; go to IDLE.
REQ-025 Ctr_Enable_Out high whenever Busy_Out is high; Ctr_Start_Out, Ctr_Stop_Out and Ctr_Reset_Out never high in the same cycle.
REQ-026 Steps values up to 2^STEP_W-1 SHALL be supported; wrap of the counter pattern is natural and is not an error.
REQ-027 Requests arriving during a run SHALL wait; minimum gap between consecutive grants is one IDLE cycle.

Reset
REQ-028 tb_Reset_In high SHALL force IDLE, Grant_Out=0, Done_Out=0, Err_Out=0, Busy_Out=0, Result_Out=0x00000000, Ctr_Start_Out=0, Ctr_Stop_Out=0, Ctr_Enable_Out=0, round-robin pointer=0, and Ctr_Reset_Out=1 asynchronously.
REQ-029 Ctr_Reset_Out SHALL drop on the first clock edge after reset release; a reset mid-run SHALL abort the run with no Done_Out pulse.

Verification
REQ-030 Req_In=0001, Steps=4 -> Grant_Out=0001; one Start and one Stop pulse; Result_Out=0x0000001F; Done_Out=0001; Err_Out=0.
REQ-031 Req_In=0010, Steps=0 -> no Start pulse; Result_Out=0x00000001; Done_Out=0010.
REQ-032 Steps=40 -> Result_Out=0xFFFFFE00; Steps=255 -> Result_Out=0x00000000.
REQ-033 Req_In=1111 simultaneously, Steps=1,2,3,4 -> grants in order 0,1,2,3; Result_Out=0x3, 0x7, 0xF, 0x1F.
REQ-034 Ctr_Running_In stuck 0 -> 8 cycles in WAIT_RUN, then Done_Out pulse with Err_Out=1; next request is served normally.
REQ-035 tb_Reset_In asserted in RUN -> all outputs at reset values immediately; no Done_Out pulse; a request after release is granted to index 0 first.
